// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and types for the display scan controller
package disp_pkg;

   // Number of multiplexed digits: hh:mm:ss
   localparam int NUM_DIGITS = 6;

   // edit_field encodings; NONE selects no field for blinking
   localparam logic [1:0] SEC  = 2'd0;
   localparam logic [1:0] MIN  = 2'd1;
   localparam logic [1:0] HOUR = 2'd2;
   localparam logic [1:0] NONE = 2'd3;

   // Page-switch FSM: RUN shows page_q, SWITCH blanks until the frame ends
   typedef logic [0:0] state_t;
   localparam state_t RUN    = 1'b0;
   localparam state_t SWITCH = 1'b1;

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - free-running slot prescaler with first/terminal count flags
module scan_prescaler #(
   parameter int SCAN_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic first,
   output logic tc
);

   localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] count_q, count_d;

   // Count 0..SCAN_DIV-1 and wrap
   always_comb begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
   end

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign first = (count_q == '0);
   assign tc    = (count_q == LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - six-digit multiplexed clock display scanner with blink and page switch
module display_scan_ctrl
   import disp_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 83
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] time_bcd,
   input  logic [4*NUM_DIGITS-1:0] alarm_bcd,
   input  logic                    page,
   input  logic                    edit_en,
   input  logic [1:0]              edit_field,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic [3:0]              cin,
   output logic                    blank,
   output logic                    frame_done
);

   localparam logic [2:0]    SLOT_LAST = 3'(NUM_DIGITS - 1);
   localparam int            FW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

   logic                  slot_first, slot_tc;
   logic [2:0]            slot_q, slot_d;
   logic [FW-1:0]         fcnt_q, fcnt_d;
   logic                  phase_q, phase_d;
   state_t                state_q, state_d;
   logic                  page_q, page_d;
   logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
   logic [3:0]            cin_q, cin_d;
   logic                  blank_q, blank_d;
   logic                  frame_end;
   logic                  blink_hit;

   scan_prescaler #(
      .SCAN_DIV (SCAN_DIV)
   ) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .first (slot_first),
      .tc    (slot_tc)
   );

   // Frame ends on the terminal count of the last slot
   assign frame_end = slot_tc && (slot_q == SLOT_LAST);

   // Slot counter steps once per prescaler wrap
   always_comb begin
      slot_d = slot_q;
      if (slot_tc) slot_d = (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;
   end

   // Blink phase flips after BLINK_FRAMES completed frames
   always_comb begin
      fcnt_d  = fcnt_q;
      phase_d = phase_q;
      if (frame_end) begin
         if (fcnt_q == FRM_LAST) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            fcnt_d = fcnt_q + FW'(1);
         end
      end
   end

   // Page switch: blank until a frame boundary, then adopt the requested page
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      case (state_q)
         RUN: begin
            if (page != page_q) state_d = SWITCH;
         end
         SWITCH: begin
            if (frame_end) begin
               state_d = RUN;
               page_d  = page;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Display outputs, registered one cycle behind the slot counter
   always_comb begin
      blink_hit   = edit_en && !phase_q && (edit_field != NONE) && (slot_q[2:1] == edit_field);
      digit_sel_d = NUM_DIGITS'(1) << slot_q;
      cin_d       = page_q ? alarm_bcd[{slot_q, 2'b00} +: 4] : time_bcd[{slot_q, 2'b00} +: 4];
      blank_d     = slot_first || (state_q == SWITCH) || blink_hit;
   end

   // State registers; reset abandons any frame or page switch in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q      <= 3'd0;
         fcnt_q      <= '0;
         phase_q     <= 1'b1;
         state_q     <= RUN;
         page_q      <= 1'b0;
         digit_sel_q <= NUM_DIGITS'(1);
         cin_q       <= 4'd0;
         blank_q     <= 1'b1;
      end else begin
         slot_q      <= slot_d;
         fcnt_q      <= fcnt_d;
         phase_q     <= phase_d;
         state_q     <= state_d;
         page_q      <= page_d;
         digit_sel_q <= digit_sel_d;
         cin_q       <= cin_d;
         blank_q     <= blank_d;
      end
   end

   assign digit_sel  = digit_sel_q;
   assign cin        = cin_q;
   assign blank      = blank_q;
   assign frame_done = frame_end;

endmodule
